// File: rtl/spi_master_cfg.sv
// SPI master with runtime CPOL/CPHA, programmable SCLK half-period, bit order and chip select.
// Host side uses a start/ready/done handshake. Every output comes straight from a flop.
module spi_master_cfg #(
    parameter int  DATA_WIDTH = 8,
    parameter int  NUM_CS     = 1,
    parameter int  DIV_WIDTH  = 16,
    localparam int CSW        = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [DATA_WIDTH-1:0] din_i,
    input  logic                  start_i,
    input  logic                  cpol_i,
    input  logic                  cpha_i,
    input  logic                  lsb_first_i,
    input  logic [DIV_WIDTH-1:0]  clk_div_i,
    input  logic [CSW-1:0]        cs_sel_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  spi_done_tick_o,
    output logic                  ready_o,
    output logic                  sclk_o,
    output logic                  mosi_o,
    input  logic                  miso_i,
    output logic [NUM_CS-1:0]     cs_n_o
);
    localparam int             ECW       = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH:0]    hcnt_q;
    logic [ECW-1:0]        ecnt_q;
    logic [DATA_WIDTH-1:0] tx_q, rx_q, rx_d;
    logic [DIV_WIDTH-1:0]  div_q;
    logic                  cpha_q, lsb_q;
    logic                  start_acc, half_end, sclk_edge, leading, shift_out, capture;

    function automatic logic head(input logic [DATA_WIDTH-1:0] sr, input logic lsb);
        return lsb ? sr[0] : sr[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] drop(input logic [DATA_WIDTH-1:0] sr, input logic lsb);
        return lsb ? (sr >> 1) : (sr << 1);
    endfunction

    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
        logic [NUM_CS-1:0] cs;
        cs = '1;
        for (int i = 0; i < NUM_CS; i++)
            if (int'(sel) == i) cs[i] = 1'b0;
        return cs;
    endfunction

    // NOTE: sequential state uses <= so every flop sees pre-edge values of its peers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // NOTE: each combinational output is defaulted first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = LEAD;
            LEAD:    if (half_end) state_d = XFER;
            XFER:    if (half_end && (ecnt_q == LAST_EDGE)) state_d = TRAIL;
            TRAIL:   if (half_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ecnt_q holds the number of SCLK edges already issued, so its LSB tells
    // whether the coming edge is leading and whether the last one was a sampling edge.
    always_comb begin
        start_acc = (state_q == IDLE) && start_i;
        half_end  = (state_q != IDLE) && (hcnt_q == {1'b0, div_q});
        sclk_edge = half_end && ((state_q == LEAD) || (state_q == XFER));
        leading   = ~ecnt_q[0];
        shift_out = sclk_edge && (cpha_q ? leading : (!leading && (ecnt_q != LAST_EDGE)));
        capture   = half_end && (state_q != LEAD) && (ecnt_q[0] != cpha_q);
        rx_d      = rx_q;
        if (capture)
            rx_d = lsb_q ? {miso_i, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hcnt_q          <= '0;
            ecnt_q          <= '0;
            tx_q            <= '0;
            rx_q            <= '0;
            div_q           <= '0;
            cpha_q          <= 1'b0;
            lsb_q           <= 1'b0;
            dout_o          <= '0;
            spi_done_tick_o <= 1'b0;
            ready_o         <= 1'b1;
            sclk_o          <= 1'b0;
            mosi_o          <= 1'b0;
            cs_n_o          <= '1;
        end else begin
            spi_done_tick_o <= 1'b0;
            rx_q            <= rx_d;
            hcnt_q          <= (state_q == IDLE || half_end) ? '0 : hcnt_q + 1'b1;

            if (state_q == IDLE) sclk_o <= cpol_i;
            if (sclk_edge) begin
                sclk_o <= ~sclk_o;
                ecnt_q <= ecnt_q + 1'b1;
            end
            if (shift_out) begin
                mosi_o <= head(tx_q, lsb_q);
                tx_q   <= drop(tx_q, lsb_q);
            end

            // CPHA=0 must show its first bit before the first SCLK edge.
            if (start_acc) begin
                cpha_q  <= cpha_i;
                lsb_q   <= lsb_first_i;
                div_q   <= clk_div_i;
                tx_q    <= cpha_i ? din_i : drop(din_i, lsb_first_i);
                rx_q    <= '0;
                ecnt_q  <= '0;
                ready_o <= 1'b0;
                cs_n_o  <= cs_decode(cs_sel_i);
                if (!cpha_i) mosi_o <= head(din_i, lsb_first_i);
            end

            if ((state_q == TRAIL) && half_end) begin
                spi_done_tick_o <= 1'b1;
                ready_o         <= 1'b1;
                cs_n_o          <= '1;
                dout_o          <= rx_d;
            end
        end
    end
endmodule

// File: doc/spi_master_cfg.md
Name: spi_master_cfg

Overview:
Parametrised successor to the team's fixed 8-bit, single-mode SPI master. It adds configurable word width and chip-select count, runtime CPOL/CPHA mode, a programmable SCLK divider and MSB/LSB-first ordering. The block sits between a host-side start/ready/done handshake and the SPI pins. It is the DUT driven by the next-generation SPI UVC.

Parameters:
DATA_WIDTH, 8, bits per transfer (W), legal values 2..32
NUM_CS, 1, number of active-low chip selects
DIV_WIDTH, 16, width of the clock-divider input

Ports:
clk_i  input  1  system clock; all logic on posedge
rst_ni  input  1  asynchronous, active-low reset
din_i  input  DATA_WIDTH  transmit word, sampled on accepted start
start_i  input  1  transfer request, accepted only when ready_o=1
cpol_i  input  1  SCLK idle level
cpha_i  input  1  0: sample on leading edge; 1: sample on trailing edge
lsb_first_i  input  1  1: shift LSB first; 0: shift MSB first
clk_div_i  input  DIV_WIDTH  half-period H = clk_div_i+1 system clocks
cs_sel_i  input  CSW  target slave; CSW = (NUM_CS>1) ? $clog2(NUM_CS) : 1
dout_o  output  DATA_WIDTH  received word
spi_done_tick_o  output  1  one-cycle pulse at end of transfer
ready_o  output  1  1 = idle, start accepted
sclk_o  output  1  SPI clock
mosi_o  output  1  serial data out
miso_i  input  1  serial data in
cs_n_o  output  NUM_CS  chip selects, active low

Behaviour:
- Reset values (async, immediate, including mid-transfer): ready_o=1, spi_done_tick_o=0, dout_o=0, sclk_o=0, mosi_o=0, cs_n_o=all 1s, FSM=IDLE, counters=0.
- On reset release, the block is in IDLE. Any abort by reset leaves dout_o=0 and produces no done tick.
- FSM states: IDLE -> LEAD -> XFER -> TRAIL -> IDLE. All outputs are registered.
- IDLE:
  - sclk_o <= cpol_i every cycle.
  - If start_i=1 at edge T: latch din_i, cpol_i, cpha_i, lsb_first_i, clk_div_i and cs_sel_i; go to LEAD.
  - Input changes after T have no effect on the transfer in progress.
- LEAD (starts at T+1):
  - ready_o=0 and cs_n_o[cs_sel]=0.
  - If cs_sel >= NUM_CS, no CS asserts but the transfer still runs.
  - If CPHA=0, mosi_o presents the first bit at T+1.
  - Duration is H cycles.
- XFER:
  - 2W SCLK edges, one every H cycles. The first edge is at T+1+H; the last is at T+1+2W·H.
  - Shift-out edges: CPHA=0 shifts on trailing edges and does not shift after the last bit. CPHA=1 drives each bit on its leading edge.
  - miso_i is captured on the last system clock of the half-period following each sampling edge.
- TRAIL: H cycles with sclk_o at CPOL.
- End of transfer, at edge T+1+(2W+1)·H:
  - cs_n_o returns to all 1s.
  - spi_done_tick_o=1 for exactly one cycle.
  - ready_o=1.
  - dout_o updated with the assembled word.
- Start-to-done latency is (2W+1)·H+1 cycles.
- dout_o holds its value until the next done tick.
- Bit order: the received word is assembled in the same order as transmitted. With lsb_first=1, the first bit received lands in dout_o[0].
- start_i while ready_o=0 is ignored; there is no queuing.
- Back-to-back: start_i=1 in the done-tick cycle is accepted. cs_n_o is deasserted for exactly that one cycle.
- clk_div_i=0 gives H=1, i.e. SCLK = clk_i/2. The maximum divider gives H=2^DIV_WIDTH.
- Counters: the half-period counter is DIV_WIDTH+1 bits; the edge counter is $clog2(2W+1) bits. Neither counter wraps within a transfer.

Test Plan:
- W=8, mode 0, div 0, din 0xA5, miso looped to mosi -> mosi sequence 1,0,1,0,0,1,0,1; dout_o=0xA5; done at T+18; cs_n low for cycles T+1..T+17.
- Mode 3 (CPOL=1, CPHA=1), div 3, din 0x3C, miso tied to slave model returning 0xC3 -> sclk idles high, 16 edges at 4-cycle spacing, done at T+69, dout_o=0xC3.
- lsb_first=1, mode 1, din 0x01, slave returns 0x80 LSB-first -> first mosi bit=1, dout_o=0x80, and the ordering is checked bit-by-bit.
- NUM_CS=4: cs_sel=2 transfer, then start_i held high at the done tick with cs_sel=1 -> cs_n_o=4'b1011, one cycle of 4'b1111, then 4'b1101; two done ticks.
- start_i pulsed mid-transfer with new din and div -> ignored; original timing and data are unaffected; exactly one done tick.
- rst_ni asserted at SCLK edge 5 of 16 -> same-cycle cs_n_o=all 1s, sclk_o=0, ready_o=1, no done tick; a new transfer after reset release completes correctly.
